traffic_phase_sequencer: RTL and testbench
==========================================

// Module: traffic_phase_sequencer
// PURPOSE
//  Parametrised successor to the fixed 4-way traffic_control_system. Round-robin signal controller
//  for N_APPROACH approaches with per-approach Left/Fwd/Right/Ped/Amber lamps, programmable
//  green/amber/all-red/walk durations, latched pedestrian requests and a flashing-amber mode.
//  Timing advances on a 1-cycle tick_en strobe from an upstream prescaler.
// PARAMETERS
//  N_APPROACH   4   number of approaches (>=2); index 0=North, 1=East, 2=South, 3=West
//  CNT_W        4   width of count; every *_TICKS must be <= 2**CNT_W
//  GREEN_TICKS  10  ticks an approach holds Left/Fwd/Right green (>=1)
//  AMBER_TICKS  3   ticks of amber after green (>=1)
//  ALLRED_TICKS 1   ticks of all-red clearance (>=1)
//  PED_TICKS    6   ticks of pedestrian walk (>=1)
// PORTS
//  clk         in  1           clock, all state on rising edge
//  rst         in  1           synchronous reset, active-low (0 = reset)
//  tick_en     in  1           timing strobe; counters move only when 1
//  flash_mode  in  1           1 = flashing-amber mode, overrides sequencing
//  ped_req     in  N_APPROACH  pedestrian push-buttons, any width pulse
//  phase       out PW          active approach, PW=$clog2(N_APPROACH)
//  state       out 3           0 ALL_RED,1 GREEN,2 AMBER,3 PED_WALK,4 FLASH
//  count       out CNT_W       ticks remaining in current state minus 1
//  ped_pend    out N_APPROACH  latched, unserved pedestrian requests
//  Left,Fwd,Right out N_APPROACH  vehicle go lamps per approach
//  Amber       out N_APPROACH  amber lamp per approach
//  Ped         out N_APPROACH  walk lamp per approach
// BEHAVIOUR
//  - Reset (rst=0 at edge): state=ALL_RED, phase=N_APPROACH-1, count=ALLRED_TICKS-1, ped_pend=0,
//    walk_mask=0, after_walk=0, flash_ph=0. All lamp outputs 0 (red = absence of any go lamp).
//  - Lamps decoded combinationally from registered state/phase: zero latency from state change.
//    GREEN: Left/Fwd/Right[phase]=1. AMBER: Amber[phase]=1. PED_WALK: Ped=walk_mask.
//    FLASH: Amber={N{flash_ph}}. Never two approaches green; never Ped with any vehicle lamp.
//  - count decrements by 1 on tick_en; transition occurs on tick_en when count==0, loading
//    next state's TICKS-1 in the same edge. No tick_en -> all state frozen.
//  - Transitions: GREEN->AMBER; AMBER->ALL_RED; ALL_RED->PED_WALK if |ped_pend && !after_walk
//    (walk_mask<=ped_pend, after_walk<=1) else ->GREEN with phase<=phase+1 (wraps N_APPROACH-1->0),
//    after_walk<=0. PED_WALK->ALL_RED.
//  - ped_pend[i] sets on any cycle with ped_req[i]=1, except while PED_WALK with walk_mask[i]=1
//    (already served). On PED_WALK exit, ped_pend &= ~walk_mask and walk_mask<=0 the same edge;
//    a set for an unserved bit on that edge wins.
//  - flash_mode=1: next edge enters FLASH from any state, count<=0; flash_ph toggles on tick_en.
//    ped_pend keeps latching. flash_mode=0 in FLASH: next edge -> ALL_RED, phase=N_APPROACH-1,
//    count=ALLRED_TICKS-1, flash_ph=0, walk_mask=0, after_walk=0.
//  - Reset dominates flash_mode and tick_en; reset mid-phase drops lamps immediately.
//  - Full rotation without ped requests = N_APPROACH*(GREEN+AMBER+ALLRED) ticks (56 at defaults).
// TESTING (defaults, tick_en=1 every cycle unless stated)
//  1 Hold rst=0 3 cycles -> all lamps 0, state=0, phase=3, count=0, ped_pend=0; release ->
//    next edge state=GREEN, phase=0, count=9, Left/Fwd/Right=4'b0001.
//  2 Free run 56 ticks -> greens on phase 0,1,2,3,0 each 10 ticks, Amber 3 ticks, 1 all-red tick;
//    one-hot green checked every cycle; phase wraps 3->0.
//  3 Pulse ped_req=4'b0100 for 1 cycle during phase 1 green -> ped_pend=4'b0100 next edge; after
//    phase 1 all-red: PED_WALK, Ped=4'b0100 for 6 ticks, then ALL_RED 1 tick, GREEN phase 2,
//    ped_pend=0. Repeat press of bit 2 during walk ignored; press of bit 0 during walk stays pending.
//  4 tick_en every 3rd cycle -> every state duration x3 cycles; count holds between strobes.
//  5 flash_mode=1 mid-GREEN -> next edge no go lamps, Amber toggles 0000/1111 per tick; drop
//    flash_mode -> ALL_RED then GREEN phase 0.
//  6 rst=0 during PED_WALK -> next edge Ped=0, ped_pend=0, state=ALL_RED, phase=3.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Round-robin signal controller: N approaches cycle GREEN -> AMBER -> ALL_RED, with an optional
// pedestrian walk slot after each all-red and a flashing-amber override.
module traffic_phase_sequencer #(
    parameter int N_APPROACH   = 4,
    parameter int CNT_W        = 4,
    parameter int GREEN_TICKS  = 10,
    parameter int AMBER_TICKS  = 3,
    parameter int ALLRED_TICKS = 1,
    parameter int PED_TICKS    = 6,
    localparam int PW = (N_APPROACH > 1) ? $clog2(N_APPROACH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_en,
    input  logic                  flash_mode,
    input  logic [N_APPROACH-1:0] ped_req,
    output logic [PW-1:0]         phase,
    output logic [2:0]            state,
    output logic [CNT_W-1:0]      count,
    output logic [N_APPROACH-1:0] ped_pend,
    output logic [N_APPROACH-1:0] Left,
    output logic [N_APPROACH-1:0] Fwd,
    output logic [N_APPROACH-1:0] Right,
    output logic [N_APPROACH-1:0] Amber,
    output logic [N_APPROACH-1:0] Ped
);

    typedef enum logic [2:0] {
        S_ALL_RED  = 3'd0,
        S_GREEN    = 3'd1,
        S_AMBER    = 3'd2,
        S_PED_WALK = 3'd3,
        S_FLASH    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] AMBER_LOAD  = CNT_W'(AMBER_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] PED_LOAD    = CNT_W'(PED_TICKS - 1);
    localparam logic [PW-1:0]    LAST_PHASE  = PW'(N_APPROACH - 1);

    state_t                  state_reg, state_next;
    logic [PW-1:0]           phase_reg, phase_next;
    logic [CNT_W-1:0]        count_reg, count_next;
    logic [N_APPROACH-1:0]   ped_pend_reg, ped_pend_next;
    logic [N_APPROACH-1:0]   walk_mask_reg, walk_mask_next;
    logic                    after_walk_reg, after_walk_next;
    logic                    flash_ph_reg, flash_ph_next;
    logic [N_APPROACH-1:0]   ped_set;
    logic [N_APPROACH-1:0]   go;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= S_ALL_RED;
            phase_reg      <= LAST_PHASE;
            count_reg      <= ALLRED_LOAD;
            ped_pend_reg   <= '0;
            walk_mask_reg  <= '0;
            after_walk_reg <= 1'b0;
            flash_ph_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            count_reg      <= count_next;
            ped_pend_reg   <= ped_pend_next;
            walk_mask_reg  <= walk_mask_next;
            after_walk_reg <= after_walk_next;
            flash_ph_reg   <= flash_ph_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        count_next      = count_reg;
        walk_mask_next  = walk_mask_reg;
        after_walk_next = after_walk_reg;
        flash_ph_next   = flash_ph_reg;
        // Presses for approaches currently walking are already being served.
        ped_set         = ped_req & ~((state_reg == S_PED_WALK) ? walk_mask_reg : '0);
        ped_pend_next   = ped_pend_reg | ped_set;

        if (flash_mode && (state_reg != S_FLASH)) begin
            state_next = S_FLASH;
            count_next = '0;
        end else if (state_reg == S_FLASH) begin
            if (!flash_mode) begin
                state_next      = S_ALL_RED;
                phase_next      = LAST_PHASE;
                count_next      = ALLRED_LOAD;
                flash_ph_next   = 1'b0;
                walk_mask_next  = '0;
                after_walk_next = 1'b0;
            end else if (tick_en) begin
                flash_ph_next = ~flash_ph_reg;
            end
        end else if (tick_en) begin
            if (count_reg != '0) begin
                count_next = count_reg - 1'b1;
            end else begin
                case (state_reg)
                    S_GREEN: begin
                        state_next = S_AMBER;
                        count_next = AMBER_LOAD;
                    end
                    S_AMBER: begin
                        state_next = S_ALL_RED;
                        count_next = ALLRED_LOAD;
                    end
                    S_ALL_RED: begin
                        // At most one walk slot between consecutive greens.
                        if ((|ped_pend_reg) && !after_walk_reg) begin
                            state_next      = S_PED_WALK;
                            count_next      = PED_LOAD;
                            walk_mask_next  = ped_pend_reg;
                            after_walk_next = 1'b1;
                        end else begin
                            state_next      = S_GREEN;
                            count_next      = GREEN_LOAD;
                            phase_next      = (phase_reg == LAST_PHASE) ? '0 : phase_reg + 1'b1;
                            after_walk_next = 1'b0;
                        end
                    end
                    S_PED_WALK: begin
                        state_next     = S_ALL_RED;
                        count_next     = ALLRED_LOAD;
                        ped_pend_next  = (ped_pend_reg & ~walk_mask_reg) | ped_set;
                        walk_mask_next = '0;
                    end
                    default: begin
                        state_next = S_ALL_RED;
                        count_next = ALLRED_LOAD;
                    end
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_APPROACH; gi++) begin : g_lamp
            assign go[gi]    = (state_reg == S_GREEN) && (phase_reg == PW'(gi));
            assign Amber[gi] = ((state_reg == S_AMBER) && (phase_reg == PW'(gi)))
                             || ((state_reg == S_FLASH) && flash_ph_reg);
            assign Ped[gi]   = (state_reg == S_PED_WALK) && walk_mask_reg[gi];
        end
    endgenerate

    assign Left     = go;
    assign Fwd      = go;
    assign Right    = go;
    assign phase    = phase_reg;
    assign state    = state_reg;
    assign count    = count_reg;
    assign ped_pend = ped_pend_reg;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench: stimulus pushes model predictions per cycle, a monitor pops and compares.
module tb_traffic_phase_sequencer;

    localparam int N = 4;
    localparam int G = 10;
    localparam int A = 3;
    localparam int R = 1;
    localparam int P = 6;

    localparam int S_AR = 0;
    localparam int S_GR = 1;
    localparam int S_AM = 2;
    localparam int S_PW = 3;
    localparam int S_FL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_en;
    logic       flash_mode;
    logic [3:0] ped_req;
    logic [1:0] phase;
    logic [2:0] state;
    logic [3:0] count;
    logic [3:0] ped_pend;
    logic [3:0] Left, Fwd, Right, Amber, Ped;

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .N_APPROACH(N), .CNT_W(4), .GREEN_TICKS(G), .AMBER_TICKS(A),
        .ALLRED_TICKS(R), .PED_TICKS(P)
    ) dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .flash_mode(flash_mode),
        .ped_req(ped_req), .phase(phase), .state(state), .count(count),
        .ped_pend(ped_pend), .Left(Left), .Fwd(Fwd), .Right(Right),
        .Amber(Amber), .Ped(Ped)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] ph;
        logic [3:0] cnt;
        logic [3:0] pend;
        logic [3:0] l;
        logic [3:0] f;
        logic [3:0] r;
        logic [3:0] a;
        logic [3:0] p;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: state name, remaining ticks in state, pending/walk sets.
    int         m_st, m_ph, m_rem;
    logic [3:0] m_pend, m_walk;
    bit         m_after, m_fph;

    task automatic model_step(input bit rn, input bit tk, input bit fl, input logic [3:0] rq);
        logic [3:0] setm;
        if (!rn) begin
            m_st = S_AR; m_ph = N - 1; m_rem = R;
            m_pend = 4'b0; m_walk = 4'b0; m_after = 0; m_fph = 0;
        end else begin
            setm = rq & ~((m_st == S_PW) ? m_walk : 4'b0);
            if (m_st != S_FL && fl) begin
                m_st = S_FL; m_rem = 1;
                m_pend = m_pend | setm;
            end else if (m_st == S_FL) begin
                m_pend = m_pend | setm;
                if (!fl) begin
                    m_st = S_AR; m_ph = N - 1; m_rem = R;
                    m_fph = 0; m_walk = 4'b0; m_after = 0;
                end else if (tk) begin
                    m_fph = ~m_fph;
                end
            end else begin
                if (tk && m_rem == 1) begin
                    case (m_st)
                        S_GR: begin m_st = S_AM; m_rem = A; end
                        S_AM: begin m_st = S_AR; m_rem = R; end
                        S_AR: begin
                            if (m_pend != 4'b0 && !m_after) begin
                                m_st = S_PW; m_rem = P; m_walk = m_pend; m_after = 1;
                            end else begin
                                m_st = S_GR; m_rem = G; m_ph = (m_ph + 1) % N; m_after = 0;
                            end
                        end
                        default: begin
                            m_pend = m_pend & ~m_walk; m_walk = 4'b0;
                            m_st = S_AR; m_rem = R;
                        end
                    endcase
                end else if (tk) begin
                    m_rem = m_rem - 1;
                end
                m_pend = m_pend | setm;
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.st   = 3'(m_st);
        o.ph   = 2'(m_ph);
        o.cnt  = 4'(m_rem - 1);
        o.pend = m_pend;
        for (int i = 0; i < N; i++) begin
            o.l[i] = (m_st == S_GR) && (m_ph == i);
            o.a[i] = ((m_st == S_AM) && (m_ph == i)) || ((m_st == S_FL) && m_fph);
            o.p[i] = (m_st == S_PW) && m_walk[i];
        end
        o.f = o.l;
        o.r = o.l;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, got, req, $time);
        end
    endtask

    // One clock of stimulus; returns at the following negedge with outputs settled.
    task automatic cycle(input bit rn, input bit tk, input bit fl, input logic [3:0] rq);
        rst = rn; tick_en = tk; flash_mode = fl; ped_req = rq;
        model_step(rn, tk, fl, rq);
        exp_q.push_back(model_obs());
        @(negedge clk);
    endtask

    task automatic run_until(input int st, input int ph, input string nm);
        bit hit;
        hit = 0;
        for (int k = 0; k < 300 && !hit; k++) begin
            cycle(1, 1, 0, 4'b0);
            if (m_st == st && (ph < 0 || m_ph == ph)) hit = 1;
        end
        if (!hit) begin
            n_vec++; n_bad++;
            $display("FAIL wait_%s: state %0d not reached within 300 cycles", nm, st);
        end
    endtask

    initial begin : monitor
        obs_t e, got;
        forever begin
            @(posedge clk);
            #1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard: no expectation queued at %0t", $time);
            end else begin
                e   = exp_q.pop_front();
                got = {state, phase, count, ped_pend, Left, Fwd, Right, Amber, Ped};
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got st=%0d ph=%0d cnt=%0d pend=%b L=%b F=%b R=%b A=%b P=%b, required st=%0d ph=%0d cnt=%0d pend=%b L=%b F=%b R=%b A=%b P=%b",
                             $time, got.st, got.ph, got.cnt, got.pend, got.l, got.f, got.r, got.a, got.p,
                             e.st, e.ph, e.cnt, e.pend, e.l, e.f, e.r, e.a, e.p);
                end
            end
            chk("green_onehot", 32'($countones(Left) <= 1), 32'd1);
            chk("ped_exclusive", 32'((Ped != 4'b0) && ((Left | Fwd | Right | Amber) != 4'b0)), 32'd0);
        end
    end

    initial begin : stimulus
        bit fl;
        // Reset hold and release
        repeat (3) cycle(0, 1, 0, 4'b0);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_phase", 32'(phase), 32'd3);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_pend", 32'(ped_pend), 32'd0);
        chk("reset_lamps", 32'({Left, Fwd, Right, Amber, Ped}), 32'd0);
        cycle(1, 1, 0, 4'b0);
        chk("release_state", 32'(state), 32'd1);
        chk("release_phase", 32'(phase), 32'd0);
        chk("release_count", 32'(count), 32'd9);
        chk("release_left", 32'(Left), 32'b0001);

        // One full rotation returns to phase 0 green start
        repeat (56) cycle(1, 1, 0, 4'b0);
        chk("rotation_state", 32'(state), 32'd1);
        chk("rotation_phase", 32'(phase), 32'd0);
        chk("rotation_count", 32'(count), 32'd9);

        // Pedestrian walk after phase 1
        run_until(S_GR, 1, "green1");
        cycle(1, 1, 0, 4'b0100);
        chk("ped_latch", 32'(ped_pend), 32'b0100);
        run_until(S_PW, -1, "walk");
        chk("walk_lamps", 32'(Ped), 32'b0100);
        cycle(1, 1, 0, 4'b0101);
        chk("walk_press", 32'(ped_pend), 32'b0101);
        run_until(S_AR, -1, "post_walk_red");
        chk("walk_clear", 32'(ped_pend), 32'b0001);
        cycle(1, 1, 0, 4'b0);
        chk("walk_next_green", 32'({state, phase}), 32'({3'd1, 2'd2}));

        // Slow strobe
        for (int i = 0; i < 150; i++) cycle(1, (i % 3) == 2, 0, 4'b0);

        // Flashing amber
        run_until(S_GR, -1, "green_for_flash");
        cycle(1, 1, 1, 4'b0);
        chk("flash_enter", 32'({state, Left, Amber}), 32'({3'd4, 4'b0, 4'b0}));
        cycle(1, 1, 1, 4'b0);
        chk("flash_toggle", 32'(Amber), 32'b1111);
        repeat (6) cycle(1, 1'($urandom_range(0, 1)), 1, 4'b0010);
        cycle(1, 1, 0, 4'b0);
        chk("flash_exit", 32'({state, phase, count}), 32'({3'd0, 2'd3, 4'd0}));

        // Reset during walk
        run_until(S_PW, -1, "walk_for_reset");
        cycle(1, 1, 0, 4'b0);
        cycle(0, 1, 0, 4'b0);
        chk("reset_walk", 32'({Ped, ped_pend, state, phase}), 32'({4'b0, 4'b0, 3'd0, 2'd3}));

        // Randomized traffic
        fl = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!fl && $urandom_range(0, 299) == 0) fl = 1;
            else if (fl && $urandom_range(0, 19) == 0) fl = 0;
            cycle($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, fl,
                  ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
